// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop sync + stable-count debounce per button, plus a
// one-cycle `change` pulse per select press. Define AUTOREPEAT_EN for hold-to-repeat.

module button_debounce_chan #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic sysclk,
   input  logic reset,
   input  logic raw,
   output logic st
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1, s2;
   logic [CNT_W-1:0] cnt;

   // Any sample agreeing with the stable level restarts qualification.
   always_ff @(posedge sysclk) begin
      if (!reset) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         st  <= 1'b0;
         cnt <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == st) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            st  <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 12500000
) (
   input  logic sysclk,
   input  logic reset,
   input  logic btn_east_raw,
   input  logic btn_west_raw,
   input  logic btn_north_raw,
   input  logic btn_south_raw,
   input  logic btn_change_raw,
   output logic East,
   output logic West,
   output logic North,
   output logic South,
   output logic change
);
   localparam int NUM_LANES = 5;
   localparam int CHG_LANE  = 4;

   if (DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) <= DEBOUNCE_CYCLES ||
       (2 ** CNT_W) <= REPEAT_DELAY || (2 ** CNT_W) <= REPEAT_PERIOD) begin : g_bad_cfg
      $error("button_debounce: CNT_W too narrow or DEBOUNCE_CYCLES < 2");
   end

   logic [NUM_LANES-1:0] raw_vec, st_vec;
   logic                 chg_st, chg_st_d;

   assign raw_vec = {btn_change_raw, btn_south_raw, btn_north_raw, btn_west_raw, btn_east_raw};

   button_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_chan [NUM_LANES-1:0] (
      .sysclk (sysclk),
      .reset  (reset),
      .raw    (raw_vec),
      .st     (st_vec)
   );

   assign East   = st_vec[0];
   assign West   = st_vec[1];
   assign North  = st_vec[2];
   assign South  = st_vec[3];
   assign chg_st = st_vec[CHG_LANE];

`ifdef AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD);

   logic [CNT_W-1:0] rpt_cnt;
   logic             rpt_armed;

   // rpt_cnt holds the number of edges since the last pulse while the button stays held.
   always_ff @(posedge sysclk) begin
      if (!reset) begin
         chg_st_d  <= 1'b0;
         change    <= 1'b0;
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
      end else begin
         chg_st_d <= chg_st;
         change   <= 1'b0;
         if (!chg_st) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
         end else if (!chg_st_d) begin
            change    <= 1'b1;
            rpt_cnt   <= CNT_W'(1);
            rpt_armed <= 1'b0;
         end else if (rpt_cnt == (rpt_armed ? RPT_NEXT : RPT_FIRST)) begin
            change    <= 1'b1;
            rpt_cnt   <= CNT_W'(1);
            rpt_armed <= 1'b1;
         end else begin
            rpt_cnt <= rpt_cnt + CNT_W'(1);
         end
      end
   end
`else
   always_ff @(posedge sysclk) begin
      if (!reset) begin
         chg_st_d <= 1'b0;
         change   <= 1'b0;
      end else begin
         chg_st_d <= chg_st;
         change   <= chg_st & ~chg_st_d;
      end
   end
`endif
endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: directed scenarios then random bouncy inputs,
// checked each cycle against a sliding-window model of the debounce rules.

module tb_button_debounce;
   localparam int DC   = 4;
   localparam int RD   = 8;
   localparam int RP   = 4;
   localparam int MAXE = 4000;
`ifdef AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic sysclk = 1'b0;
   logic reset  = 1'b0;
   logic btn_east_raw = 1'b0, btn_west_raw = 1'b0, btn_north_raw = 1'b0;
   logic btn_south_raw = 1'b0, btn_change_raw = 1'b0;
   logic East, West, North, South, change;

   button_debounce #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (4),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .sysclk         (sysclk),
      .reset          (reset),
      .btn_east_raw   (btn_east_raw),
      .btn_west_raw   (btn_west_raw),
      .btn_north_raw  (btn_north_raw),
      .btn_south_raw  (btn_south_raw),
      .btn_change_raw (btn_change_raw),
      .East           (East),
      .West           (West),
      .North          (North),
      .South          (South),
      .change         (change)
   );

   always #5 sysclk = ~sysclk;

   // edge-indexed history: raw levels, reset flags and model stable levels after each edge
   logic [4:0] raw_h [0:MAXE-1];
   bit         rst_h [0:MAXE-1];
   logic [4:0] st_h  [0:MAXE-1];
   logic [4:0] exp_q [$];
   int e = 0;
   int t0 = -1000;
   int n_chk = 0, n_pass = 0;
   int chg_seen = 0;
   int mon_cyc = 0;

   // level seen by the debounce logic at edge k: raw from two edges earlier, zero near a reset
   function automatic logic s2_at(int ch, int k);
      if (k < 2) return 1'b0;
      if (rst_h[k-1] || rst_h[k-2]) return 1'b0;
      return raw_h[k-2][ch];
   endfunction

   task automatic model_edge(output logic [4:0] exp_v);
      logic [4:0] prev, prev2, ns;
      logic       chg;
      bit         ok;
      prev  = (e >= 1) ? st_h[e-1] : 5'b0;
      prev2 = (e >= 2) ? st_h[e-2] : 5'b0;
      ns    = 5'b0;
      chg   = 1'b0;
      if (!rst_h[e]) begin
         for (int ch = 0; ch < 5; ch++) begin
            // flip only after DC consecutive samples disagreeing with the current level
            ok = 1'b1;
            for (int i = 0; i < DC; i++)
               if (e - i < 2 || s2_at(ch, e - i) == prev[ch]) ok = 1'b0;
            ns[ch] = ok ? ~prev[ch] : prev[ch];
         end
         if (prev[4] && !prev2[4]) begin
            chg = 1'b1;
            t0  = e;
         end else if (AR && prev[4] && prev2[4] && (e - t0) >= RD && ((e - t0 - RD) % RP) == 0) begin
            chg = 1'b1;
         end
      end
      st_h[e] = ns;
      exp_v   = {chg, ns[3:0]};
   endtask

   task automatic step(input logic [4:0] r, input logic rn);
      logic [4:0] exp_v;
      @(negedge sysclk);
      {btn_change_raw, btn_south_raw, btn_north_raw, btn_west_raw, btn_east_raw} = r;
      reset    = rn;
      raw_h[e] = r;
      rst_h[e] = !rn;
      model_edge(exp_v);
      exp_q.push_back(exp_v);
      e++;
   endtask

   task automatic steps(input logic [4:0] r, input int n);
      for (int i = 0; i < n; i++) step(r, 1'b1);
   endtask

   // monitor: outputs are presented every cycle; compare each against the oldest expectation
   initial begin
      logic [4:0] got, want;
      forever begin
         @(posedge sysclk);
         #1;
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            got  = {change, South, North, West, East};
            if (change) chg_seen++;
            n_chk++;
            if (got === want) n_pass++;
            else $display("FAIL outs cyc %0d: got chg/S/N/W/E=%b want %b", mon_cyc, got, want);
            mon_cyc++;
         end
      end
   end

   initial begin
      logic [4:0] cur;
      int         flip_div, c0;

      for (int i = 0; i < 3; i++) step(5'b0, 1'b0);
      // clean press and release on East
      steps(5'b00001, 10);
      steps(5'b00000, 10);
      // bouncy press on North
      step(5'b00100, 1'b1); step(5'b00100, 1'b1); step(5'b00100, 1'b1);
      step(5'b00000, 1'b1);
      steps(5'b00100, 12);
      steps(5'b00000, 10);
      // select held 20 cycles: count pulses independently of the model
      c0 = chg_seen;
      steps(5'b10000, 20);
      steps(5'b00000, 15);
      n_chk++;
      if (chg_seen - c0 == (AR ? 4 : 1)) n_pass++;
      else $display("FAIL hold_pulses: got %0d pulses want %0d", chg_seen - c0, AR ? 4 : 1);
      // reset mid-count with South held
      steps(5'b01000, 3);
      step(5'b01000, 1'b0);
      steps(5'b01000, 10);
      steps(5'b00000, 10);
      // all five together
      steps(5'b11111, 12);
      steps(5'b00000, 12);
      // random bouncy inputs with occasional resets
      cur = 5'b0;
      flip_div = 3;
      for (int n = 0; n < 2500; n++) begin
         if (n % 100 == 0) flip_div = (n % 300 == 0) ? 3 : ((n % 300 == 100) ? 8 : 20);
         for (int b = 0; b < 5; b++)
            if ($urandom_range(0, flip_div - 1) == 0) cur[b] = ~cur[b];
         step(cur, ($urandom_range(0, 199) != 0));
      end
      steps(5'b00000, 2);
      @(posedge sysclk);
      @(posedge sysclk);
      #2;
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left want 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
